// File: rtl/fnd_bcd_source_pkg.sv
// fnd_bcd_source_pkg
// Shared definitions for the BCD digit source and its display consumers.
//   fsm_state_e : conversion FSM states (IDLE / SHIFT / DONE)
//   BLANK_CODE  : digit code the font decoder renders as an unlit digit
//   BCD_DIGITS  : number of BCD nibbles in the committed result
package fnd_bcd_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_e;

    localparam logic [4:0] BLANK_CODE = 5'h1F;
    localparam int         BCD_DIGITS = 4;

endpackage

// File: rtl/fnd_bcd_source_bcd_add3.sv
// bcd_add3
// Per-nibble double-dabble correction: a nibble of 5 or more gets 3 added so
// that the following left shift carries correctly into the next BCD digit.
//   nib_i : accumulator nibble before correction
//   nib_o : corrected nibble
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/fnd_bcd_source.sv
// fnd_bcd_source
// Sequential binary-to-BCD converter feeding the FND display mux. A value is
// accepted on start (IDLE only), saturated to MAX_VAL, converted one bit per
// cycle by a shift-and-add-3 engine and committed atomically to bcd_all, so
// the display never sees a partial result. digit serves the nibble selected
// by the display scan index, registered.
//
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   start, bin : conversion request and the binary value to convert
//   busy       : high from the cycle after acceptance through the DONE cycle
//   done       : one-cycle pulse when a new result is committed
//   ovf        : committed result was saturated
//   bcd_all    : committed result, four packed BCD digits, [3:0] = ones
//   digit_sel  : scan index, 0 = ones ... 3 = thousands
//   digit      : registered digit code {1'b0, nibble} or BLANK_CODE
//   state_dbg  : current FSM state, for observation
//
// Handshake: start is sampled only while IDLE; a start seen in any other state
// is dropped, not queued. done pulses exactly once per accepted start unless
// reset intervenes.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero digit (the ones digit is never blanked).
module fnd_bcd_source
    import fnd_bcd_source_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [15:0]       bcd_all,
    input  logic [1:0]        digit_sel,
    output logic [4:0]        digit,
    output fsm_state_e        state_dbg
);

    localparam int                CNT_W   = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MAX_BIN = DATA_W'(MAX_VAL);

    fsm_state_e        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [15:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_next_q, ovf_next_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       bcd_all_q, bcd_all_d;
    logic [4:0]        digit_q, digit_d;

    logic [15:0] acc_corr;
    logic [15:0] acc_shifted;
    logic [3:0]  sel_nib;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i(acc_q[4*g +: 4]),
            .nib_o(acc_corr[4*g +: 4])
        );
    end

    // Corrected accumulator shifted left, pulling in the next binary MSB.
    assign acc_shifted = {acc_corr[14:0], sh_q[DATA_W-1]};
    assign sel_nib     = bcd_all_q[{digit_sel, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] upper_digits;
    logic        blank;
    // A digit is blank when it and every digit above it are zero.
    assign upper_digits = bcd_all_q >> {digit_sel, 2'b00};
    assign blank        = (digit_sel != 2'd0) && (upper_digits == 16'h0000);
`endif

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_all_d  = bcd_all_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d       = (bin > MAX_BIN) ? MAX_BIN : bin;
                    ovf_next_d = (bin > MAX_BIN);
                    acc_d      = 16'h0000;
                    cnt_d      = CNT_W'(DATA_W);
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                // Last shift: commit so the result is visible during DONE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    bcd_all_d = acc_shifted;
                    ovf_d     = ovf_next_q;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        digit_d = blank ? BLANK_CODE : {1'b0, sel_nib};
`else
        digit_d = {1'b0, sel_nib};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            acc_q      <= 16'h0000;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_all_q  <= 16'h0000;
            digit_q    <= 5'h00;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_all_q  <= bcd_all_d;
            digit_q    <= digit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign bcd_all   = bcd_all_q;
    assign digit     = digit_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fnd_bcd_source.sv
module tb_fnd_bcd_source;
    import fnd_bcd_source_pkg::*;

    localparam int DATA_W  = 14;
    localparam int MAX_VAL = 9999;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] bin;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [15:0]       bcd_all;
    logic [1:0]        digit_sel;
    logic [4:0]        digit;
    fsm_state_e        state_dbg;

    int total = 0;
    int bad   = 0;

    fnd_bcd_source #(.DATA_W(DATA_W), .MAX_VAL(MAX_VAL)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf), .bcd_all(bcd_all),
        .digit_sel(digit_sel), .digit(digit), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] bin;
        logic [15:0]       bcd;
        logic              ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected scan output for a committed value and a select index.
    function automatic logic [4:0] exp_digit(input logic [15:0] bcd, input logic [1:0] sel);
        logic [3:0] nib;
        nib = bcd[{sel, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (sel != 2'd0 && (bcd >> {sel, 2'b00}) == 16'h0000) return 5'h1F;
`endif
        return {1'b0, nib};
    endfunction

    // Waits for done with a cycle budget; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // Full handshake for one value: acceptance, latency, result, release.
    task automatic run_conv(input logic [DATA_W-1:0] v, input logic [15:0] exp_bcd,
                            input logic exp_ovf);
        int n;
        bin   = v;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("no_early_done", done, 1'b0);
        wait_done(n);
        check("done_latency", n, DATA_W);
        check("bcd_all", bcd_all, exp_bcd);
        check("ovf", ovf, exp_ovf);
        check("busy_in_done", busy, 1'b1);
        step();
        check("done_pulse_width", done, 1'b0);
        check("busy_release", busy, 1'b0);
        check("state_idle", state_dbg, ST_IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;

        vecs[0] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
        vecs[1] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
        vecs[2] = '{bin: 14'd12000, bcd: 16'h9999, ovf: 1'b1};
        vecs[3] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0};
        vecs[4] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
        vecs[5] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
        vecs[6] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
        vecs[7] = '{bin: 14'd1,     bcd: 16'h0001, ovf: 1'b0};
        vecs[8] = '{bin: 14'd908,   bcd: 16'h0908, ovf: 1'b0};

        // Clock/reset
        reset     = 1'b1;
        start     = 1'b0;
        bin       = '0;
        digit_sel = 2'd0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_bcd_all", bcd_all, 16'h0000);
        check("rst_digit", digit, 5'h00);
        check("rst_state", state_dbg, ST_IDLE);

        // Table-driven conversions plus a scan of all four digits.
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
            for (int s = 0; s < 4; s++) begin
                digit_sel = 2'(s);
                step();
                check($sformatf("digit_v%0d_s%0d", i, s), digit, exp_digit(vecs[i].bcd, 2'(s)));
            end
        end

        // start held through busy and DONE: one pulse only, new bin ignored.
        bin   = 14'd42;
        start = 1'b1;
        step();
        bin    = 14'd7777;
        pulses = 0;
        for (int c = 0; c < DATA_W + 1; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("held_start_pulses", pulses, 1);
        check("held_start_bcd", bcd_all, 16'h0042);
        check("held_start_busy", busy, 1'b0);
        run_conv(14'd7777, 16'h7777, 1'b0);

        // Reset mid-SHIFT aborts the conversion.
        digit_sel = 2'd0;
        step();
        check("pre_abort_digit", digit, exp_digit(16'h7777, 2'd0));
        bin   = 14'd1234;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bcd_all", bcd_all, 16'h0000);
        check("abort_digit", digit, 5'h00);
        check("abort_state", state_dbg, ST_IDLE);
        pulses = 0;
        for (int c = 0; c < DATA_W + 4; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_conv(14'd2468, 16'h2468, 1'b0);

        // start and reset together: reset wins.
        bin   = 14'd55;
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        check("start_vs_reset_busy", busy, 1'b0);
        check("start_vs_reset_state", state_dbg, ST_IDLE);
        check("start_vs_reset_bcd", bcd_all, 16'h0000);

        // digit follows a bcd_all update one cycle after done.
        digit_sel = 2'd2;
        step();
        check("sel2_before", digit, exp_digit(16'h0000, 2'd2));
        bin   = 14'd300;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        check("sel2_latency", n, DATA_W);
        check("sel2_at_done", digit, exp_digit(16'h0000, 2'd2));
        step();
        check("sel2_after_done", digit, 5'h03);
        check("sel2_bcd", bcd_all, 16'h0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_bcd_source.md
# fnd_bcd_source

Sequential binary-to-BCD digit source that produces the per-digit values consumed by the FND display controller. It accepts a binary value (sensor reading or time count) through a start/done handshake and converts it with a shift-and-add-3 (double-dabble) engine. It then serves one 5-bit digit code per scan-select index, in step with the display's digit scan counter. It sits between the value producers (sensor/timer blocks) and the display mux.

## Interface

Parameters:
- DATA_W, 14: binary input width. Legal range 4..14.
- MAX_VAL, 9999: saturation limit. Must be ≤ 9999 and ≤ 2^DATA_W−1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request conversion of `bin`. Sampled only in IDLE.
- bin  in  DATA_W  unsigned binary value. Captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when a new result is committed.
- ovf  out  1  set when the committed result was saturated.
- bcd_all  out  16  committed result, four packed BCD digits; [3:0] is the ones digit.
- digit_sel  in  2  scan index; 0 selects ones, 3 selects thousands.
- digit  out  5  registered digit code {1'b0, bcd}, or blank code 5'h1F.

## Operation

- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE with start=1:
  - Capture min(bin, MAX_VAL) into the shift register.
  - Capture ovf_next = (bin > MAX_VAL).
  - Clear the BCD accumulator and load shift count = DATA_W.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every accumulator nibble ≥ 5.
  - Then shift {accumulator, binary} left by one.
  - Decrement the count. When the count reaches 0, go to DONE.
- DONE:
  - Commit the accumulator to bcd_all and ovf_next to ovf.
  - Pulse done and go to IDLE.
- start while busy or in DONE is ignored; it is not queued.
- bcd_all and ovf hold the previous result throughout a conversion, so the display never shows partial values.
- Accumulator width is 16 bits. The count register is clog2(DATA_W+1) bits.
- digit: registered, giving bcd_all nibble [digit_sel] one cycle after digit_sel, subject to blanking (see Configuration).

## Timing

- Reset values: busy=0, done=0, ovf=0, bcd_all=16'h0000, digit=5'h00. The FSM returns to IDLE.
- Latency:
  - Start accepted at cycle t; busy=1 from t+1 to t+DATA_W+1.
  - done=1 and the new bcd_all/ovf appear at cycle t+DATA_W+1.
  - busy=0 from t+DATA_W+2.
  - The next start is accepted at t+DATA_W+2 at the earliest.
- Throughput: one conversion per DATA_W+2 cycles.
- digit latency: 1 cycle from a digit_sel change, and 1 cycle after the bcd_all update.
- Reset mid-conversion: the conversion is aborted and no done pulse is produced. All outputs return to their reset values on the next edge.
- start and reset in the same cycle: reset wins.

## Configuration

- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit outputs 5'h1F for every nibble above the most significant nonzero digit. The ones digit is never blanked, so 0 displays as a single "0".
- Undefined: digit always outputs {1'b0, nibble}, and code 5'h1F is never produced.
- bcd_all is unaffected either way.

## Structure

- Shared package holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - the BLANK_CODE constant 5'h1F, shared with the display font decoder;
  - the BCD_DIGITS constant 4.
- One sub-module: `bcd_add3`, the per-nibble combinational correction (nibble ≥ 5 → nibble+3), instantiated 4 times.

## Test plan

- bin=1234, start pulse at cycle t → done at t+15, bcd_all=16'h1234, ovf=0. digit_sel 0..3 → 04,03,02,01 (one cycle later).
- bin=0 → bcd_all=16'h0000. With LEADING_ZERO_BLANK_EN, digit_sel 0..3 → 00,1F,1F,1F.
- bin=12000 → bcd_all=16'h9999, ovf=1. A following conversion of bin=5 → ovf=0, bcd_all=16'h0005.
- bin=42, then start held high during busy with bin=7777 → exactly one done pulse, bcd_all=16'h0042. A new start after busy falls → 16'h7777.
- reset asserted mid-SHIFT (cycle t+6) → no done pulse, busy=0, bcd_all=0, digit=0 on the next edge. A new start converts normally.
- bcd_all update while digit_sel=2 held, value 0→0300 → digit changes 00→03 exactly one cycle after done.
